fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage. It is the producer side of the IF/ID pipeline register: it generates instr_i, npc_i, phit_i and bp_ai, which IF/ID latches when its EN is high.
- Owns the PC register.
- Issues instruction-memory reads and handles icache wait states.
- Predicts taken branches with a direct-mapped BTB using 2-bit counters.
- Applies redirects from branch/jump resolution in later stages.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset
BTB_ENTRIES, 16, number of BTB entries; power of two, at least 2
IDX_W, $clog2(BTB_ENTRIES), BTB index width (derived; do not override)

Ports:
CLK  in  1  clock; all state updates on posedge
RST  in  1  synchronous, active-high reset
imemREN  out  1  instruction read request
imemaddr  out  32  instruction address (= PC)
ihit  in  1  icache returns imemload this cycle
imemload  in  32  fetched instruction word
pipe_en  in  1  IF/ID EN from hazard unit (stage may advance)
halt  in  1  halt request from decode
redirect  in  1  later stage resolved a mispredict or jump
redirect_pc  in  32  corrected PC
bpu_update  in  1  resolved branch training strobe
bpu_pc  in  32  PC of the resolved branch
bpu_taken  in  1  actual branch outcome
bpu_target  in  32  actual branch target
instr_i  out  32  instruction to IF/ID
npc_i  out  32  PC+4 to IF/ID
phit_i  out  1  BTB predicted taken
bp_ai  out  32  predicted next PC to IF/ID

Behaviour:
- Reset (sync, RST=1 at posedge):
  - pc <= PC_INIT; halted <= 0.
  - All BTB valid bits cleared; tags, targets and counters are don't-care.
  - Reset takes priority over every other input, including during an outstanding icache miss.
- imemREN = !halted; imemaddr = pc.
- BTB lookup (combinational on pc):
  - Index idx = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2].
  - phit_i = valid[idx] & (tag match) & ctr[idx][1].
  - bp_ai = phit_i ? target[idx] : pc+4.
- IF/ID outputs:
  - instr_i = (ihit & !halted) ? imemload : 32'h0 (nop bubble).
  - npc_i = pc+4 (32-bit wrap; 32'hFFFF_FFFC+4 = 0).
- Fetch completion: advance = ihit & pipe_en & !halted.
- Next-PC priority:
  1. RST -> PC_INIT.
  2. redirect -> redirect_pc. Applied even when halted, and clears halted. Any fetch in that cycle is discarded; IF/ID flush is asserted by the hazard unit, not by this block.
  3. halt -> hold pc; halted <= 1 (sticky until redirect or RST).
  4. advance -> bp_ai.
  5. Otherwise hold pc (icache miss or stall).
- Latency: a hit with pipe_en=1 lands in IF/ID next cycle; back-to-back hits give 1 instr/cycle. A miss inserts nops while pc holds.
- BTB update (at posedge when bpu_update=1), at bpu_pc index/tag:
  - Miss (invalid or tag mismatch) and bpu_taken=1: allocate valid=1, tag, target=bpu_target, ctr=2'b10.
  - Miss and bpu_taken=0: no change.
  - Hit: ctr saturating +1 if taken, -1 if not (bounds 2'b00..2'b11). Target overwritten when taken.
  - A lookup in the same cycle as an update to the same index sees the pre-update entry (write-at-edge).
- bpu_update and redirect in the same cycle are independent; both take effect.

Decomposition:
- Package fetch_pkg:
  - word_t (32-bit).
  - ctr_t (2-bit) with constants SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - btb_entry_t struct {valid, tag, target, ctr}.
  - NOP constant 32'h0.
- Sub-module btb: registered entry array with a combinational read port (pc -> phit, target) and a sync update port.
- fetch_unit contains the PC register, halt flag and next-PC mux.

Test Plan:
- Reset, then ihit=1 and pipe_en=1 for 3 cycles with no BTB entries -> imemaddr 0x0, 0x4, 0x8; npc_i 0x4, 0x8, 0xC; phit_i=0.
- At pc=0x10, ihit=0 for 2 cycles then 1 -> pc stays 0x10; instr_i=0 during the miss; imemload presented on the hit cycle; pc becomes 0x14.
- Train bpu_pc=0x20, target 0x100, taken, once -> next fetch of 0x20 gives phit_i=1, bp_ai=0x100, next pc 0x100. Two not-taken updates -> phit_i=0, bp_ai=0x24.
- Train taken 3 more times (ctr=ST), then one not-taken -> still predicts taken (ctr=WT).
- Same cycle: redirect=1 (redirect_pc=0x200), ihit=1, pipe_en=1, phit_i=1 -> next pc=0x200, not the BTB target.
- halt at pc=0x40 -> imemREN=0, pc held across 5 cycles. Then redirect to 0x80 -> fetch resumes at 0x80. RST during halt -> pc=PC_INIT, BTB empty.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types, counter encodings and helpers for the
//                instruction-fetch stage and its branch target buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Machine word used for PCs, targets and instruction words
  typedef logic [31:0] word_t;

  // 2-bit saturating branch direction counter
  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'b00;  // strongly not taken
  localparam ctr_t WNT = 2'b01;  // weakly not taken
  localparam ctr_t WT  = 2'b10;  // weakly taken
  localparam ctr_t ST  = 2'b11;  // strongly taken

  // Bubble inserted into IF/ID when no instruction is delivered
  localparam word_t NOP = 32'h0000_0000;

  // The tag field holds the full word address pc[31:2]. The index bits are
  // redundant with the slot position, which keeps the struct independent of
  // the BTB depth while giving the same match result as a trimmed tag.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    word_t       target;
    ctr_t        ctr;
  } btb_entry_t;

  // Saturating counter step toward the resolved outcome
  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    ctr_t r;
    r = c;
    if (taken) begin
      if (c != ST) r = c + 2'd1;
    end else begin
      if (c != SNT) r = c - 2'd1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btb.sv
`default_nettype none
// ============================================================================
//  Module      : btb
//  Description : Direct-mapped branch target buffer with 2-bit counters.
//                Combinational lookup port, single synchronous update port.
//                A lookup concurrent with an update sees the old entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module btb
  import fetch_pkg::*;
#(
  parameter int BTB_ENTRIES = 16,
  parameter int IDX_W       = $clog2(BTB_ENTRIES)
) (
  input  logic  CLK,
  input  logic  RST,
  // lookup port
  input  word_t rd_pc_i,
  output logic  rd_hit_o,
  output word_t rd_target_o,
  // training port
  input  logic  upd_i,
  input  word_t upd_pc_i,
  input  logic  upd_taken_i,
  input  word_t upd_target_i
);

  btb_entry_t       entry_q [BTB_ENTRIES];
  btb_entry_t       entry_d;

  logic [IDX_W-1:0] w_rd_idx;
  btb_entry_t       w_rd_entry;
  logic [IDX_W-1:0] w_upd_idx;
  btb_entry_t       w_upd_entry;
  logic             w_upd_hit;
  logic             w_upd_write;

  // Byte-offset bits never participate in indexing or tagging
  logic w_unused_bits;
  assign w_unused_bits = ^{rd_pc_i[1:0], upd_pc_i[1:0]};

  assign w_rd_idx   = rd_pc_i[IDX_W+1:2];
  assign w_rd_entry = entry_q[w_rd_idx];

  // Predict taken only on a valid tag match whose counter leans taken
  assign rd_hit_o    = w_rd_entry.valid &&
                       (w_rd_entry.tag == rd_pc_i[31:2]) &&
                       w_rd_entry.ctr[1];
  assign rd_target_o = w_rd_entry.target;

  assign w_upd_idx   = upd_pc_i[IDX_W+1:2];
  assign w_upd_entry = entry_q[w_upd_idx];
  assign w_upd_hit   = w_upd_entry.valid &&
                       (w_upd_entry.tag == upd_pc_i[31:2]);

  // Compute the trained entry: allocate on a taken miss, step counter on hit
  always_comb begin
    entry_d     = w_upd_entry;
    w_upd_write = 1'b0;
    if (upd_i) begin
      if (w_upd_hit) begin
        w_upd_write = 1'b1;
        entry_d.ctr = ctr_next(w_upd_entry.ctr, upd_taken_i);
        if (upd_taken_i) entry_d.target = upd_target_i;
      end else if (upd_taken_i) begin
        w_upd_write    = 1'b1;
        entry_d.valid  = 1'b1;
        entry_d.tag    = upd_pc_i[31:2];
        entry_d.target = upd_target_i;
        entry_d.ctr    = WT;
      end
    end
  end

  // Entry storage: reset invalidates every slot, otherwise write the trained entry
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        entry_q[i].valid <= 1'b0;
      end
    end else if (w_upd_write) begin
      entry_q[w_upd_idx] <= entry_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage. Owns the PC, issues icache reads,
//                predicts with a BTB and applies later-stage redirects.
//                Produces the IF/ID inputs instr_i, npc_i, phit_i, bp_ai.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter word_t PC_INIT     = 32'h0000_0000,
  parameter int    BTB_ENTRIES = 16,
  localparam int   IDX_W       = $clog2(BTB_ENTRIES)
) (
  input  logic        CLK,
  input  logic        RST,
  // instruction memory
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  // pipeline control
  input  logic        pipe_en,
  input  logic        halt,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  // predictor training
  input  logic        bpu_update,
  input  logic [31:0] bpu_pc,
  input  logic        bpu_taken,
  input  logic [31:0] bpu_target,
  // IF/ID outputs
  output logic [31:0] instr_i,
  output logic [31:0] npc_i,
  output logic        phit_i,
  output logic [31:0] bp_ai
);

  word_t pc_q, pc_d;
  logic  halted_q, halted_d;

  word_t w_pc_plus4;
  logic  w_btb_hit;
  word_t w_btb_target;
  logic  w_advance;

  btb #(
    .BTB_ENTRIES (BTB_ENTRIES),
    .IDX_W       (IDX_W)
  ) u_btb (
    .CLK          (CLK),
    .RST          (RST),
    .rd_pc_i      (pc_q),
    .rd_hit_o     (w_btb_hit),
    .rd_target_o  (w_btb_target),
    .upd_i        (bpu_update),
    .upd_pc_i     (bpu_pc),
    .upd_taken_i  (bpu_taken),
    .upd_target_i (bpu_target)
  );

  assign w_pc_plus4 = pc_q + 32'd4;
  assign w_advance  = ihit && pipe_en && !halted_q;

  assign imemREN  = !halted_q;
  assign imemaddr = pc_q;

  assign phit_i  = w_btb_hit;
  assign bp_ai   = w_btb_hit ? w_btb_target : w_pc_plus4;
  assign npc_i   = w_pc_plus4;
  assign instr_i = (ihit && !halted_q) ? imemload : NOP;

  // Next-PC selection: redirect beats halt, halt beats a completed fetch
  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q;
    if (redirect) begin
      pc_d     = redirect_pc;
      halted_d = 1'b0;
    end else if (halt) begin
      halted_d = 1'b1;
    end else if (w_advance) begin
      pc_d = bp_ai;
    end
  end

  // PC and halt flag registers; reset overrides any pending fetch
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q     <= PC_INIT;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed scoreboard bench for fetch_unit. The driver pushes
//                the hand-computed expected outputs for every cycle it drives;
//                a monitor pops and compares them mid-cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        CLK;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        pipe_en;
  logic        halt;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        bpu_update;
  logic [31:0] bpu_pc;
  logic        bpu_taken;
  logic [31:0] bpu_target;
  logic [31:0] instr_i;
  logic [31:0] npc_i;
  logic        phit_i;
  logic [31:0] bp_ai;

  typedef struct {
    logic        ren;
    logic [31:0] addr;
    logic [31:0] npc;
    logic        ph;
    logic [31:0] bp;
    logic [31:0] ins;
    int          step;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   step_no  = 0;

  fetch_unit #(
    .PC_INIT     (32'h0000_0000),
    .BTB_ENTRIES (16)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .imemREN     (imemREN),
    .imemaddr    (imemaddr),
    .ihit        (ihit),
    .imemload    (imemload),
    .pipe_en     (pipe_en),
    .halt        (halt),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bpu_update  (bpu_update),
    .bpu_pc      (bpu_pc),
    .bpu_taken   (bpu_taken),
    .bpu_target  (bpu_target),
    .instr_i     (instr_i),
    .npc_i       (npc_i),
    .phit_i      (phit_i),
    .bp_ai       (bp_ai)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int stp, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL step %0d %s: got 0x%08h expected 0x%08h", stp, name, act, expv);
    end
  endtask

  // Monitor: compares the outputs of each driven cycle at the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("imemREN",  e.step, {31'd0, imemREN}, {31'd0, e.ren});
        chk("imemaddr", e.step, imemaddr, e.addr);
        chk("npc_i",    e.step, npc_i,    e.npc);
        chk("phit_i",   e.step, {31'd0, phit_i}, {31'd0, e.ph});
        chk("bp_ai",    e.step, bp_ai,    e.bp);
        chk("instr_i",  e.step, instr_i,  e.ins);
      end
    end
  end

  task automatic idle();
    RST         = 1'b0;
    ihit        = 1'b0;
    imemload    = 32'h0;
    pipe_en     = 1'b0;
    halt        = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    bpu_update  = 1'b0;
    bpu_pc      = 32'h0;
    bpu_taken   = 1'b0;
    bpu_target  = 32'h0;
  endtask

  // Record expectations for the inputs already applied, then advance a cycle
  task automatic tick(input logic ren, input logic [31:0] addr, input logic [31:0] npc,
                      input logic ph, input logic [31:0] bp, input logic [31:0] ins);
    exp_t e;
    step_no++;
    e.ren = ren; e.addr = addr; e.npc = npc; e.ph = ph; e.bp = bp; e.ins = ins;
    e.step = step_no;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    idle();
  endtask

  task automatic fetch(input logic [31:0] load);
    ihit = 1'b1; pipe_en = 1'b1; imemload = load;
  endtask

  task automatic redir(input logic [31:0] pc);
    redirect = 1'b1; redirect_pc = pc;
  endtask

  task automatic train(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    bpu_update = 1'b1; bpu_pc = pc; bpu_taken = tk; bpu_target = tgt;
  endtask

  initial begin
    idle();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    // reset held: state already at PC_INIT with an empty BTB
    RST = 1'b1;
    tick(1, 32'h0, 32'h4, 0, 32'h4, 32'h0);
    // sequential hits, no predictions
    fetch(32'hA0); tick(1, 32'h00, 32'h04, 0, 32'h04, 32'hA0);
    fetch(32'hA1); tick(1, 32'h04, 32'h08, 0, 32'h08, 32'hA1);
    fetch(32'hA2); tick(1, 32'h08, 32'h0C, 0, 32'h0C, 32'hA2);
    fetch(32'hA3); tick(1, 32'h0C, 32'h10, 0, 32'h10, 32'hA3);
    // icache miss at 0x10 for two cycles, then hit
    pipe_en = 1; imemload = 32'hDEAD; tick(1, 32'h10, 32'h14, 0, 32'h14, 32'h0);
    pipe_en = 1; imemload = 32'hDEAD; tick(1, 32'h10, 32'h14, 0, 32'h14, 32'h0);
    fetch(32'h1234); tick(1, 32'h10, 32'h14, 0, 32'h14, 32'h1234);
    // hit with pipe_en low holds the PC
    fetch(32'h4321); pipe_en = 0; tick(1, 32'h14, 32'h18, 0, 32'h18, 32'h4321);
    // redirect to 0x20 while allocating 0x20 -> 0x100 (independent)
    redir(32'h20); train(32'h20, 1, 32'h100); tick(1, 32'h14, 32'h18, 0, 32'h18, 32'h0);
    // predicted taken fetch follows the BTB target
    fetch(32'h55); tick(1, 32'h20, 32'h24, 1, 32'h100, 32'h55);
    // two not-taken updates drop the prediction
    redir(32'h20); train(32'h20, 0, 32'h0); tick(1, 32'h100, 32'h104, 0, 32'h104, 32'h0);
    train(32'h20, 0, 32'h0); tick(1, 32'h20, 32'h24, 0, 32'h24, 32'h0);
    fetch(32'h66); tick(1, 32'h20, 32'h24, 0, 32'h24, 32'h66);
    // three taken updates saturate, one not-taken keeps predicting taken
    train(32'h20, 1, 32'h100); tick(1, 32'h24, 32'h28, 0, 32'h28, 32'h0);
    train(32'h20, 1, 32'h100); tick(1, 32'h24, 32'h28, 0, 32'h28, 32'h0);
    train(32'h20, 1, 32'h100); tick(1, 32'h24, 32'h28, 0, 32'h28, 32'h0);
    train(32'h20, 0, 32'h0); redir(32'h20); tick(1, 32'h24, 32'h28, 0, 32'h28, 32'h0);
    // redirect beats a predicted hit; concurrent update not visible this cycle
    fetch(32'h77); redir(32'h200); train(32'h20, 1, 32'h300);
    tick(1, 32'h20, 32'h24, 1, 32'h100, 32'h77);
    fetch(32'h88); redir(32'h20); tick(1, 32'h200, 32'h204, 0, 32'h204, 32'h88);
    // retrained target now visible
    redir(32'h3C); tick(1, 32'h20, 32'h24, 1, 32'h300, 32'h0);
    fetch(32'h99); tick(1, 32'h3C, 32'h40, 0, 32'h40, 32'h99);
    // halt at 0x40: request still active this cycle, then stops
    fetch(32'hAA); halt = 1; tick(1, 32'h40, 32'h44, 0, 32'h44, 32'hAA);
    for (int k = 0; k < 5; k++) begin
      fetch(32'hBB); tick(0, 32'h40, 32'h44, 0, 32'h44, 32'h0);
    end
    // redirect while halted resumes fetching
    fetch(32'hBB); redir(32'h80); tick(0, 32'h40, 32'h44, 0, 32'h44, 32'h0);
    fetch(32'hCC); tick(1, 32'h80, 32'h84, 0, 32'h84, 32'hCC);
    halt = 1; tick(1, 32'h84, 32'h88, 0, 32'h88, 32'h0);
    // reset during halt
    fetch(32'hDD); RST = 1; tick(0, 32'h84, 32'h88, 0, 32'h88, 32'h0);
    redir(32'h20); tick(1, 32'h0, 32'h4, 0, 32'h4, 32'h0);
    // BTB emptied by reset
    redir(32'hFFFF_FFFC); tick(1, 32'h20, 32'h24, 0, 32'h24, 32'h0);
    // PC+4 wraps to zero
    fetch(32'hEE); tick(1, 32'hFFFF_FFFC, 32'h0, 0, 32'h0, 32'hEE);
    tick(1, 32'h0, 32'h4, 0, 32'h4, 32'h0);

    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge CLK);
    #1;
    if (exp_q.size() > 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
